// File: rtl/count_toggle_pkg.sv
// rtl/count_toggle_pkg.sv - shared defaults for the multi-channel count/toggle block
package count_toggle_pkg;

    localparam int DEFAULT_NUM_CH    = 4;
    localparam int DEFAULT_CNT_WIDTH = 24;

endpackage

// File: rtl/count_toggle_channel.sv
// rtl/count_toggle_channel.sv - one enable-gated counter with terminal tick and toggle
module count_toggle_channel #(
    parameter int CNT_WIDTH = 24
) (
    input  logic                 i_Clk,
    input  logic                 i_Reset,
    input  logic                 i_Sync,
    input  logic                 i_Enable,
    input  logic [CNT_WIDTH-1:0] i_Limit,
    output logic                 o_Tick,
    output logic                 o_Toggle,
    output logic [CNT_WIDTH-1:0] o_Count
);

    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    logic                 parked;
    logic                 terminal;
    logic [CNT_WIDTH-1:0] limit_m1;

    // limit_m1 is only consulted when i_Limit >= 1, so it never underflows in use
    assign parked   = (i_Limit == CNT_ZERO) || !i_Enable;
    assign limit_m1 = i_Limit - CNT_ONE;
    assign terminal = (o_Count >= limit_m1);

    always_ff @(posedge i_Clk) begin
        if (i_Reset || i_Sync || parked) begin
            o_Count  <= CNT_ZERO;
            o_Tick   <= 1'b0;
            o_Toggle <= 1'b0;
        end else if (terminal) begin
            o_Count  <= CNT_ZERO;
            o_Tick   <= 1'b1;
            o_Toggle <= ~o_Toggle;
        end else begin
            o_Count  <= o_Count + CNT_ONE;
            o_Tick   <= 1'b0;
        end
    end

endmodule

// File: rtl/multi_count_toggle.sv
// rtl/multi_count_toggle.sv - NUM_CH independent count/tick/toggle channels on one clock
module multi_count_toggle
    import count_toggle_pkg::*;
#(
    parameter int NUM_CH    = DEFAULT_NUM_CH,
    parameter int CNT_WIDTH = DEFAULT_CNT_WIDTH
) (
    input  logic                        i_Clk,
    input  logic                        i_Reset,
    input  logic                        i_Sync,
    input  logic [NUM_CH-1:0]           i_Enable,
    input  logic [NUM_CH*CNT_WIDTH-1:0] i_Limit,
    output logic [NUM_CH-1:0]           o_Tick,
    output logic [NUM_CH-1:0]           o_Toggle,
    output logic [NUM_CH*CNT_WIDTH-1:0] o_Count
);

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        count_toggle_channel #(
            .CNT_WIDTH(CNT_WIDTH)
        ) u_channel (
            .i_Clk    (i_Clk),
            .i_Reset  (i_Reset),
            .i_Sync   (i_Sync),
            .i_Enable (i_Enable[k]),
            .i_Limit  (i_Limit[k*CNT_WIDTH +: CNT_WIDTH]),
            .o_Tick   (o_Tick[k]),
            .o_Toggle (o_Toggle[k]),
            .o_Count  (o_Count[k*CNT_WIDTH +: CNT_WIDTH])
        );
    end

endmodule

// File: tb/tb_multi_count_toggle.sv
// tb/tb_multi_count_toggle.sv - directed and soak checks for multi_count_toggle
module tb_multi_count_toggle;

    localparam int NCH = 4;
    localparam int CW  = 24;

    logic              i_Clk = 1'b0;
    logic              rst   = 1'b1;
    logic              sync  = 1'b0;
    logic [NCH-1:0]    en    = '0;
    logic [NCH*CW-1:0] lim   = '0;
    logic [NCH-1:0]    tick;
    logic [NCH-1:0]    tog;
    logic [NCH*CW-1:0] cnt;

    logic       rst4  = 1'b1;
    logic       sync4 = 1'b0;
    logic [0:0] en4   = '0;
    logic [3:0] lim4  = '0;
    logic [0:0] tick4;
    logic [0:0] tog4;
    logic [3:0] cnt4;

    int tests  = 0;
    int failed = 0;

    always #5 i_Clk = ~i_Clk;

    multi_count_toggle #(.NUM_CH(NCH), .CNT_WIDTH(CW)) dut (
        .i_Clk    (i_Clk),
        .i_Reset  (rst),
        .i_Sync   (sync),
        .i_Enable (en),
        .i_Limit  (lim),
        .o_Tick   (tick),
        .o_Toggle (tog),
        .o_Count  (cnt)
    );

    multi_count_toggle #(.NUM_CH(1), .CNT_WIDTH(4)) dut4 (
        .i_Clk    (i_Clk),
        .i_Reset  (rst4),
        .i_Sync   (sync4),
        .i_Enable (en4),
        .i_Limit  (lim4),
        .o_Tick   (tick4),
        .o_Toggle (tog4),
        .o_Count  (cnt4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_Clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_lim(input int ch, input int v);
        lim[ch*CW +: CW] = CW'(v);
    endtask

    function automatic logic [31:0] count_of(input int ch);
        return 32'(cnt[ch*CW +: CW]);
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    logic [3:0] m_cnt;
    logic       m_tick;
    logic       m_tog;

    initial begin
        // 1: reset behaviour and first-period latency, L=3 on all channels
        en = 4'hF;
        for (int k = 0; k < NCH; k++) set_lim(k, 3);
        steps(2);
        chk("rst_count", 32'(cnt == '0), 32'd1);
        chk("rst_tick", 32'(tick), 32'd0);
        chk("rst_toggle", 32'(tog), 32'd0);
        rst = 1'b0;
        step();
        chk("t1_e0_count", count_of(0), 32'd1);
        chk("t1_e0_tick", 32'(tick), 32'd0);
        step();
        chk("t1_e1_count", count_of(3), 32'd2);
        step();
        chk("t1_e2_tick", 32'(tick), 32'hF);
        chk("t1_e2_toggle", 32'(tog), 32'hF);
        chk("t1_e2_count", count_of(1), 32'd0);
        step();
        chk("t1_e3_tick", 32'(tick), 32'd0);
        chk("t1_e3_toggle", 32'(tog), 32'hF);
        steps(2);
        chk("t1_e5_tick", 32'(tick), 32'hF);
        chk("t1_e5_toggle", 32'(tog), 32'h0);

        // mid-period reset discards the count and emits no tick
        step();
        rst = 1'b1;
        step();
        chk("mid_rst_count", count_of(2), 32'd0);
        chk("mid_rst_tick", 32'(tick), 32'd0);
        rst = 1'b0;

        // 2: limits ch0=1 ch1=2 ch2=5 ch3=0, all enabled
        set_lim(0, 1); set_lim(1, 2); set_lim(2, 5); set_lim(3, 0);
        do_reset();
        for (int i = 1; i <= 10; i++) begin
            step();
            chk($sformatf("t2_tick_%0d", i), 32'(tick),
                {28'd0, 1'b0, 1'(i % 5 == 0), 1'(i % 2 == 0), 1'b1});
            chk($sformatf("t2_tog_%0d", i), 32'(tog),
                {28'd0, 1'b0, 1'((i / 5) % 2), 1'((i / 2) % 2), 1'(i % 2)});
            chk($sformatf("t2_ch3_count_%0d", i), count_of(3), 32'd0);
        end

        // 3: ch2 L=5 enable dropped at count 3, then re-enabled
        en = 4'b0100;
        do_reset();
        steps(5);
        chk("t3_first_tick", 32'(tick[2]), 32'd1);
        chk("t3_first_tog", 32'(tog[2]), 32'd1);
        steps(3);
        chk("t3_count3", count_of(2), 32'd3);
        en = 4'b0000;
        step();
        chk("t3_drop_count", count_of(2), 32'd0);
        chk("t3_drop_tog", 32'(tog[2]), 32'd0);
        chk("t3_drop_tick", 32'(tick[2]), 32'd0);
        en = 4'b0100;
        steps(4);
        chk("t3_re_no_tick", 32'(tick[2]), 32'd0);
        chk("t3_re_count4", count_of(2), 32'd4);
        step();
        chk("t3_re_tick", 32'(tick[2]), 32'd1);
        chk("t3_re_tog", 32'(tog[2]), 32'd1);

        // 4: ch0 L=100, shrink to 10 at count 50
        en = 4'b0001;
        set_lim(0, 100);
        do_reset();
        steps(50);
        chk("t4_count50", count_of(0), 32'd50);
        chk("t4_no_tick", 32'(tick[0]), 32'd0);
        set_lim(0, 10);
        step();
        chk("t4_shrink_tick", 32'(tick[0]), 32'd1);
        chk("t4_shrink_count", count_of(0), 32'd0);
        steps(9);
        chk("t4_p10_no_tick", 32'(tick[0]), 32'd0);
        chk("t4_p10_count9", count_of(0), 32'd9);
        step();
        chk("t4_p10_tick", 32'(tick[0]), 32'd1);

        // 5: L=4 and L=6 free-running, then a sync pulse
        en = 4'b0011;
        set_lim(0, 4); set_lim(1, 6);
        do_reset();
        steps(7);
        sync = 1'b1;
        step();
        sync = 1'b0;
        chk("t5_sync_count0", count_of(0), 32'd0);
        chk("t5_sync_count1", count_of(1), 32'd0);
        chk("t5_sync_tog", 32'(tog), 32'd0);
        chk("t5_sync_tick", 32'(tick), 32'd0);
        for (int i = 1; i <= 12; i++) begin
            step();
            chk($sformatf("t5_tick_%0d", i), 32'(tick),
                {30'd0, 1'(i % 6 == 0), 1'(i % 4 == 0)});
        end
        chk("t5_joint_tog", 32'(tog), {30'd0, 1'b0, 1'b1});

        // 6: 4-bit counter, L=15 reaches 14 then wraps to 0
        en4 = 1'b1;
        lim4 = 4'd15;
        step();
        rst4 = 1'b0;
        steps(14);
        chk("t6_count14", 32'(cnt4), 32'd14);
        chk("t6_no_tick", 32'(tick4), 32'd0);
        step();
        chk("t6_tick", 32'(tick4), 32'd1);
        chk("t6_wrap", 32'(cnt4), 32'd0);

        // soak against a behavioural model
        m_cnt  = cnt4;
        m_tick = tick4[0];
        m_tog  = tog4[0];
        for (int i = 0; i < 300; i++) begin
            en4   = 1'($urandom_range(0, 9) != 0);
            sync4 = 1'($urandom_range(0, 39) == 0);
            rst4  = 1'($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 14) == 0) lim4 = 4'($urandom_range(0, 15));
            step();
            if (rst4 || sync4 || lim4 == 4'd0 || !en4) begin
                m_cnt = 4'd0; m_tick = 1'b0; m_tog = 1'b0;
            end else if (int'(m_cnt) + 1 >= int'(lim4)) begin
                m_cnt = 4'd0; m_tick = 1'b1; m_tog = ~m_tog;
            end else begin
                m_cnt = m_cnt + 4'd1; m_tick = 1'b0;
            end
            chk("soak_count", 32'(cnt4), 32'(m_cnt));
            chk("soak_tick", 32'(tick4), 32'(m_tick));
            chk("soak_tog", 32'(tog4), 32'(m_tog));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
